// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: channel map, clock rate and
// the per-channel status bundle produced by each input debouncer.
package traffic_pkg;

    localparam int NUM_CH = 6;
    localparam int CLK_HZ = 1000;

    localparam int CH_SS_PED      = 0;
    localparam int CH_CS_PED      = 1;
    localparam int CH_SS_STRAIGHT = 2;
    localparam int CH_SS_TURN     = 3;
    localparam int CH_CS_STRAIGHT = 4;
    localparam int CH_CS_TURN     = 5;

    typedef struct packed {
        logic debounced;
        logic pulse;
        logic stuck;
    } ch_status_t;

endpackage

// File: rtl/input_debouncer.sv
// One input channel: two-flop synchroniser, debounce counter, rising-edge detect
// and stuck-high detection.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int STUCK_CYCLES    = 120000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw,
    output ch_status_t status
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic               s1;
    logic               s2;
    logic               deb;
    logic               deb_q;
    logic [DEB_W-1:0]   deb_cnt;
    logic [STUCK_W-1:0] stuck_cnt;
    logic               stuck;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            deb       <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt   <= '0;
            stuck_cnt <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_q <= deb;

            // Toggle only after DEBOUNCE_CYCLES consecutive mismatching samples.
            if (s2 != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= ~deb;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end

            if (!deb) begin
                stuck_cnt <= '0;
            end else if (stuck_cnt != STUCK_MAX) begin
                stuck_cnt <= stuck_cnt + 1'b1;
            end
        end
    end

    // Saturated count doubles as the stuck flag; it drops one edge after deb falls.
    assign stuck = (stuck_cnt == STUCK_MAX);

    assign status.debounced = deb;
    assign status.pulse     = deb & ~deb_q & ~stuck;
    assign status.stuck     = stuck;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions raw buttons/sensors into latched service requests, one debouncer per
// channel, with stuck-on channels masked from requesting.
module traffic_request_conditioner #(
    parameter int NUM_CH          = traffic_pkg::NUM_CH,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int STUCK_CYCLES    = 120000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic [NUM_CH-1:0] service_clear,
    output logic [NUM_CH-1:0] debounced,
    output logic [NUM_CH-1:0] request_pulse,
    output logic [NUM_CH-1:0] request,
    output logic [NUM_CH-1:0] stuck,
    output logic              any_request
);

    import traffic_pkg::*;

    ch_status_t [NUM_CH-1:0] ch_status;
    logic       [NUM_CH-1:0] req_q;
    logic       [NUM_CH-1:0] req_d;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .STUCK_CYCLES    (STUCK_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_in[ch]),
            .status (ch_status[ch])
        );

        assign debounced[ch]     = ch_status[ch].debounced;
        assign request_pulse[ch] = ch_status[ch].pulse;
        assign stuck[ch]         = ch_status[ch].stuck;
    end

    // A new press wins over a clear on the same edge; stuck channels never hold a request.
    always_comb begin
        req_d = ~stuck & (request_pulse | (req_q & ~service_clear));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign request     = req_q & ~stuck;
    assign any_request = |request;

endmodule
